// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the MaxNet control path: FSM state encoding and network sizing.
// No logic, so it has no latency and no backpressure.
package nn_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_INIT  = 3'd2,
    S_MULT  = 3'd3,
    S_UPD   = 3'd4,
    S_CHECK = 3'd5,
    S_RES   = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  localparam int DEFAULT_MAX_ITER = 15;
  localparam int NUM_NEURONS      = 4;
  localparam int CNT_W            = 3;
  localparam int IDX_W            = 2;

endpackage

// File: rtl/active_encoder.sv
// Survivor encoder: counts the set bits of a 4-bit activity vector and finds the lowest set index.
// Purely combinational with zero latency; it has no flow control and no backpressure.
module active_encoder
  import nn_ctrl_pkg::*;
(
  input  logic [NUM_NEURONS-1:0] vec,
  output logic [CNT_W-1:0]       cnt,
  output logic [IDX_W-1:0]       idx,
  output logic                   one_hot
);

  always_comb begin
    cnt = '0;
    idx = '0;
    // Scanning from the top down leaves the lowest set index as the last assignment.
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      cnt = cnt + CNT_W'(vec[i]);
      if (vec[i]) idx = IDX_W'(i);
    end
    one_hot = (cnt == CNT_W'(1));
  end

endmodule

// File: rtl/maxnet_sequencer.sv
// MaxNet iteration controller: sequences the datapath load strobes, checks convergence, reports status.
// A run of N rounds ends with done 3N+4 cycles after the start edge; start edges outside IDLE are ignored.
module maxnet_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int MAX_ITER = DEFAULT_MAX_ITER,
  parameter int ITER_W   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_NEURONS-1:0] active,
  output logic                   ldI,
  output logic                   ldInit,
  output logic                   ldM,
  output logic                   ldA,
  output logic                   ldRes,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic                   no_win,
  output logic [IDX_W-1:0]       winner,
  output logic [ITER_W-1:0]      iter
);

  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

  state_t              state;
  state_t              next_state;
  logic                start_q;
  logic                launch;
  logic                at_limit;
  logic [ITER_W-1:0]   iter_q;
  logic [IDX_W-1:0]    winner_q;
  logic                timeout_q;
  logic                no_win_q;
  logic [CNT_W-1:0]    act_cnt;
  logic [IDX_W-1:0]    act_idx;
  logic                act_one_hot;

  active_encoder u_enc (
    .vec     (active),
    .cnt     (act_cnt),
    .idx     (act_idx),
    .one_hot (act_one_hot)
  );

  assign launch   = start && !start_q;
  assign at_limit = (iter_q == ITER_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (launch) next_state = S_LOAD;
      S_LOAD:  next_state = S_INIT;
      S_INIT:  next_state = S_MULT;
      S_MULT:  next_state = S_UPD;
      S_UPD:   next_state = S_CHECK;
      S_CHECK: begin
        if (act_one_hot || act_cnt == '0 || at_limit) next_state = S_RES;
        else                                          next_state = S_MULT;
      end
      S_RES:   next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // start_q resets high so a start already asserted when reset lifts is not taken as an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q   <= 1'b1;
      iter_q    <= '0;
      winner_q  <= '0;
      timeout_q <= 1'b0;
      no_win_q  <= 1'b0;
    end else begin
      start_q <= start;
      case (state)
        S_IDLE: begin
          if (launch) begin
            iter_q    <= '0;
            winner_q  <= '0;
            timeout_q <= 1'b0;
            no_win_q  <= 1'b0;
          end
        end
        S_UPD: begin
          if (!at_limit) iter_q <= iter_q + ITER_W'(1);
        end
        S_CHECK: begin
          if (act_one_hot) begin
            winner_q <= act_idx;
          end else if (act_cnt == '0) begin
            no_win_q <= 1'b1;
          end else if (at_limit) begin
            timeout_q <= 1'b1;
            winner_q  <= act_idx;
          end
        end
        default: ;
      endcase
    end
  end

  assign ldI     = (state == S_LOAD);
  assign ldInit  = (state == S_INIT);
  assign ldM     = (state == S_MULT);
  assign ldA     = (state == S_UPD);
  assign ldRes   = (state == S_RES);
  assign done    = (state == S_DONE);
  assign busy    = (state != S_IDLE) && (state != S_DONE);
  assign timeout = timeout_q;
  assign no_win  = no_win_q;
  assign iter    = iter_q;
  // A forced stop or an empty network has no meaningful winner, so it reads as 0.
  assign winner  = (done && !timeout_q && !no_win_q) ? winner_q : '0;

endmodule

// File: doc/maxnet_sequencer.md
# maxnet_sequencer

Iteration controller for the four-neuron MaxNet datapath. It sequences the datapath load strobes through input capture, activation init, repeated inhibition/update rounds and result capture. After each round it checks convergence using the datapath's per-neuron activity flags and stops on a single winner, on no survivor, or at an iteration limit. It sits beside the datapath inside the top-level network and replaces a free-running controller with an edge-triggered start, a bounded loop and status reporting.

## Interface
- MAX_ITER, 15, maximum inhibition rounds before forced termination (1..2^ITER_W-1)
- ITER_W, 4, width of iteration counter
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  run request; a run launches on a 0→1 transition sampled in IDLE
- active  in  4  datapath flags: bit i = activation of neuron i is > 0 (valid after each ldA)
- ldI  out  1  capture inp1..inp4 into input registers
- ldInit  out  1  copy inputs into activation registers
- ldM  out  1  latch inhibition products
- ldA  out  1  latch updated activations
- ldRes  out  1  latch max output register
- busy  out  1  high from LOAD through RES inclusive
- done  out  1  one-cycle pulse in DONE
- timeout  out  1  run ended at MAX_ITER with >1 survivor; valid from DONE until next launch
- no_win  out  1  run ended with zero survivors; same validity as timeout
- winner  out  2  index of surviving neuron; valid when done and !no_win and !timeout, else 0
- iter  out  ITER_W  rounds completed in current/last run

## Operation
- States: IDLE, LOAD, INIT, MULT, UPD, CHECK, RES, DONE. Exactly one strobe or flag per state: LOAD→ldI, INIT→ldInit, MULT→ldM, UPD→ldA, RES→ldRes, DONE→done.
- IDLE: if start && !start_q → LOAD, clear timeout/no_win/winner/iter. start_q is a registered copy of start.
- LOAD→INIT→MULT unconditionally. MULT→UPD. UPD: iter <= iter+1, →CHECK.
- CHECK uses popcount(active):
  - 1 → RES; winner <= index of set bit.
  - 0 → RES; no_win <= 1.
  - ≥2 and iter == MAX_ITER → RES; timeout <= 1; winner <= lowest set index, reported as 0 because timeout gates it.
  - ≥2 otherwise → MULT.
- RES→DONE→IDLE.
- start edges while busy or in DONE are ignored. A held-high start never relaunches; start must return low first.
- iter saturates at MAX_ITER and never wraps.

## Timing
- Reset: state IDLE; all outputs 0; iter 0; start_q reset to 1, so a start held high across reset deassertion does not launch.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0; no done pulse.
- Start edge sampled at cycle 0 (IDLE). ldI at cycle 1, ldInit at 2, ldM at 3, ldA at 4, CHECK at 5.
- For a run of N rounds: ldRes at cycle 3N+3, done at cycle 3N+4. N=1 gives done at 7.
- active is sampled only in CHECK, which is the cycle after ldA, so it reflects the updated activations.
- All outputs are registered or decoded from the state register only; there is no combinational path from active or start to outputs.

## Structure
- Shared package nn_ctrl_pkg: state enum encoding, DEFAULT_MAX_ITER = 15, NUM_NEURONS = 4.
- One combinational sub-module, active_encoder: 4-bit in; outputs cnt[2:0], lowest-set index[1:0], and one_hot flag. The same module can be reused by the datapath's max selection.
- Everything else (FSM, start edge detect, iteration counter, status registers) stays in maxnet_sequencer.

## Test plan
- Single round: start edge, active=4'b0100 at CHECK → strobes at cycles 1..6, done at 7, winner=2, iter=1, timeout=0, no_win=0.
- Three rounds: active=0111, then 0011, then 1000 → ldM pulses at cycles 3, 6, 9; done at 13; winner=3; iter=3.
- Timeout with MAX_ITER=2: active held 0011 → done at 10, timeout=1, winner=0, iter=2.
- No survivor: active=0000 at first CHECK → done at 7, no_win=1, winner=0.
- Reset mid-run: assert rst low during UPD → all outputs 0 immediately, no done. Release rst with start held high → no launch. Drop start, raise it again → run launches normally.
- Start abuse: a second start edge at cycle 3 and start held high through DONE → exactly one run and one done pulse; busy low after DONE.
